// File: rtl/barrett_pkg.sv
// Shared types and defaults for the Barrett reduction scheduler.
package barrett_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  localparam int RED_LAT_DEF = 14;
  localparam int OPW         = 64;

endpackage

// File: rtl/rsp_fifo.sv
// First-word-fall-through response FIFO; head reads as zero while empty.
module rsp_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             full_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign count_o   = wr_ptr_r - rd_ptr_r;
  assign empty_o   = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (count_o == CW'(DEPTH));
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_s || do_pop_s);
  assign head_o    = empty_o ? '0 : mem_r[rd_ptr_r[AW-1:0]];

  // pointer update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // storage write
  always_ff @(posedge clk_i) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/shiftreg.sv
// Fixed-depth register pipeline with asynchronous clear.
module shiftreg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // shift one stage per clock
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign q_o = stage_r[DEPTH-1];

endmodule

// File: rtl/barrett_sched.sv
// Round-robin scheduler sharing one pipelined Barrett reducer among requesters,
// with credit-based flow control into an in-order response FIFO.
module barrett_sched
  import barrett_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int RED_LAT    = RED_LAT_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [NUM_REQ*OPW-1:0] req_x_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [OPW-1:0]         cfg_m_i,
  input  logic [OPW-1:0]         cfg_m_bl_i,
  input  logic [OPW-1:0]         cfg_mu_i,
  output logic                   red_start_o,
  output logic [OPW-1:0]         red_x_o,
  output logic [OPW-1:0]         red_m_o,
  output logic [OPW-1:0]         red_m_bl_o,
  output logic [OPW-1:0]         red_mu_o,
  input  logic [OPW-1:0]         red_result_i,
  input  logic                   red_valid_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [OPW-1:0]         rsp_data_o,
  output logic [IDW-1:0]         rsp_id_o,
  output logic                   err_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  sched_state_t     state_r, state_s;
  logic             cfg_ready_r, cfg_ready_s;
  logic             err_r;
  logic [OPW-1:0]   m_r, m_bl_r, mu_r;
  logic             red_start_r;
  logic [OPW-1:0]   red_x_r;
  logic [IDW-1:0]   red_id_r;
  logic [IDW-1:0]   prio_r;
  logic [CW-1:0]    inflight_r, inflight_s;
  logic [CW-1:0]    fifo_count_s;
  logic [CW:0]      used_s;
  logic             credit_ok_s;
  logic             grant_en_s;
  logic             cfg_hs_s, cfg_bad_s, cfg_load_s, err_set_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic             gnt_any_s;
  logic [IDW-1:0]   gnt_id_s, idx_s;
  logic [OPW-1:0]   gnt_x_s;
  logic [IDW:0]     tag_out_s;
  logic             tag_v_s, push_s, pop_s, mismatch_s, empty_s;
  logic [IDW+OPW-1:0] head_s;

  assign cfg_hs_s    = cfg_valid_i && cfg_ready_r;
  assign cfg_bad_s   = (cfg_m_i == 64'd0);
  assign used_s      = {1'b0, inflight_r} + {1'b0, fifo_count_s};
  assign credit_ok_s = (used_s < (CW+1)'(FIFO_DEPTH));
  assign tag_v_s     = tag_out_s[IDW];
  assign push_s      = red_valid_i && tag_v_s;
  assign mismatch_s  = red_valid_i ^ tag_v_s;
  assign pop_s       = rsp_valid_o && rsp_ready_i;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_r <= UNCFG;
    else         state_r <= state_s;
  end

  // FSM next-state logic; a zero modulus always falls back to UNCFG
  always_comb begin
    state_s = state_r;
    case (state_r)
      UNCFG:   if (cfg_hs_s && !cfg_bad_s) state_s = RUN;   else state_s = UNCFG;
      RUN:     if (cfg_valid_i)            state_s = DRAIN; else state_s = RUN;
      DRAIN:   if (cfg_hs_s)               state_s = cfg_bad_s ? UNCFG : RUN;
               else                        state_s = DRAIN;
      default: state_s = UNCFG;
    endcase
  end

  // FSM outputs; cfg_ready is precomputed for the next state so it can be registered
  always_comb begin
    grant_en_s = (state_r == RUN) && !cfg_valid_i && credit_ok_s;
    cfg_load_s = cfg_hs_s && !cfg_bad_s;
    err_set_s  = (cfg_hs_s && cfg_bad_s) || mismatch_s;
    case (state_s)
      UNCFG:   cfg_ready_s = 1'b1;
      DRAIN:   cfg_ready_s = (inflight_s == '0);
      default: cfg_ready_s = 1'b0;
    endcase
  end

  // round-robin pick starting at prio_r
  always_comb begin
    gnt_s     = '0;
    gnt_id_s  = '0;
    gnt_any_s = 1'b0;
    gnt_x_s   = '0;
    idx_s     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = IDW'((int'(prio_r) + k) % NUM_REQ);
      if (grant_en_s && !gnt_any_s && req_valid_i[idx_s]) begin
        gnt_any_s     = 1'b1;
        gnt_id_s      = idx_s;
        gnt_s[idx_s]  = 1'b1;
        gnt_x_s       = req_x_i[int'(idx_s)*OPW +: OPW];
      end else begin
        gnt_s = gnt_s;
      end
    end
  end

  assign req_ready_o = gnt_s;

  // outstanding reducer operations
  always_comb begin
    case ({gnt_any_s, tag_v_s})
      2'b10:   inflight_s = inflight_r + CW'(1);
      2'b01:   inflight_s = inflight_r - CW'(1);
      default: inflight_s = inflight_r;
    endcase
  end

  // control, configuration and issue registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_ready_r <= 1'b0;
      err_r       <= 1'b0;
      m_r         <= '0;
      m_bl_r      <= '0;
      mu_r        <= '0;
      red_start_r <= 1'b0;
      red_x_r     <= '0;
      red_id_r    <= '0;
      prio_r      <= '0;
      inflight_r  <= '0;
    end else begin
      cfg_ready_r <= cfg_ready_s;
      err_r       <= err_r || err_set_s;
      inflight_r  <= inflight_s;
      red_start_r <= gnt_any_s;
      if (cfg_load_s) begin
        m_r    <= cfg_m_i;
        m_bl_r <= cfg_m_bl_i;
        mu_r   <= cfg_mu_i;
      end
      if (gnt_any_s) begin
        red_x_r  <= gnt_x_s;
        red_id_r <= gnt_id_s;
        prio_r   <= (int'(gnt_id_s) == NUM_REQ-1) ? '0 : gnt_id_s + IDW'(1);
      end
    end
  end

  // {valid, id} travels alongside the operand through the reducer
  shiftreg #(
    .WIDTH(IDW+1),
    .DEPTH(RED_LAT)
  ) u_tag_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    ({red_start_r, red_id_r}),
    .q_o    (tag_out_s)
  );

  rsp_fifo #(
    .WIDTH(IDW+OPW),
    .DEPTH(FIFO_DEPTH),
    .CW   (CW)
  ) u_rsp_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push_s),
    .push_data_i ({tag_out_s[IDW-1:0], red_result_i}),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .empty_o     (empty_s),
    .count_o     (fifo_count_s)
  );

  assign rsp_valid_o = !empty_s;
  assign rsp_data_o  = head_s[OPW-1:0];
  assign rsp_id_o    = head_s[OPW +: IDW];
  assign cfg_ready_o = cfg_ready_r;
  assign err_o       = err_r;
  assign red_start_o = red_start_r;
  assign red_x_o     = red_x_r;
  assign red_m_o     = m_r;
  assign red_m_bl_o  = m_bl_r;
  assign red_mu_o    = mu_r;

endmodule

// File: tb/tb_barrett_sched.sv
// Directed bench for barrett_sched with a behavioural fixed-latency reducer.
`timescale 1ns/1ps
module tb_barrett_sched;

  localparam int NUM_REQ = 4;
  localparam int RED_LAT = 14;
  localparam int FIFO_DEPTH = 16;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b1;
  logic [NUM_REQ-1:0] req_valid_i, req_ready_o;
  logic [NUM_REQ*64-1:0] req_x_i;
  logic cfg_valid_i, cfg_ready_o;
  logic [63:0] cfg_m_i, cfg_m_bl_i, cfg_mu_i;
  logic red_start_o;
  logic [63:0] red_x_o, red_m_o, red_m_bl_o, red_mu_o, red_result_i;
  logic red_valid_i;
  logic rsp_valid_o, rsp_ready_i;
  logic [63:0] rsp_data_o;
  logic [1:0] rsp_id_o;
  logic err_o;

  barrett_sched #(.NUM_REQ(NUM_REQ), .RED_LAT(RED_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_x_i(req_x_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_m_i(cfg_m_i), .cfg_m_bl_i(cfg_m_bl_i), .cfg_mu_i(cfg_mu_i),
    .red_start_o(red_start_o), .red_x_o(red_x_o), .red_m_o(red_m_o),
    .red_m_bl_o(red_m_bl_o), .red_mu_o(red_mu_o),
    .red_result_i(red_result_i), .red_valid_i(red_valid_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_id_o(rsp_id_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // behavioural reducer: x mod m after RED_LAT cycles, plus an injectable stray valid
  logic        mdl_v [RED_LAT];
  logic [63:0] mdl_d [RED_LAT];
  logic        inj_v = 1'b0;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < RED_LAT; k++) begin mdl_v[k] <= 1'b0; mdl_d[k] <= 64'd0; end
    end else begin
      mdl_v[0] <= red_start_o;
      mdl_d[0] <= (red_m_o != 64'd0) ? (red_x_o % red_m_o) : 64'd0;
      for (int k = 1; k < RED_LAT; k++) begin mdl_v[k] <= mdl_v[k-1]; mdl_d[k] <= mdl_d[k-1]; end
    end
  end
  assign red_valid_i  = mdl_v[RED_LAT-1] | inj_v;
  assign red_result_i = mdl_d[RED_LAT-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int          gnt_q[$], gnt_cyc_q[$], rx_id_q[$], rx_cyc_q[$];
  logic [63:0] rx_data_q[$];

  // monitor: handshakes observed mid-cycle, after stimulus has settled
  always begin
    @(negedge clk_i); #2;
    checks++;
    if ($countones(req_ready_o) > 1) begin
      errors++;
      $display("FAIL grant_onehot: req_ready_o=%b, required at most one bit", req_ready_o);
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (req_valid_i[i] && req_ready_o[i]) begin gnt_q.push_back(i); gnt_cyc_q.push_back(cyc); end
    if (rsp_valid_o && rsp_ready_i) begin
      rx_id_q.push_back(int'(rsp_id_o)); rx_data_q.push_back(rsp_data_o); rx_cyc_q.push_back(cyc);
    end
  end

  typedef struct { int id; logic [63:0] x; logic [63:0] exp_data; } vec_t;
  vec_t vecs [6];
  logic [63:0] exp97  [4] = '{64'd5, 64'd8, 64'd11, 64'd14};
  logic [63:0] exp101 [4] = '{64'd5, 64'd4, 64'd3, 64'd2};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic clear_q();
    gnt_q.delete(); gnt_cyc_q.delete(); rx_id_q.delete(); rx_data_q.delete(); rx_cyc_q.delete();
  endtask

  task automatic wait_rx(input int n, input int bound, input string name);
    int k = 0;
    while (rx_data_q.size() < n && k < bound) begin tick(); k++; end
    chk(name, rx_data_q.size(), n);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready_o, 0);
    chk({tag, "_cfg_ready"}, cfg_ready_o, 0);
    chk({tag, "_red_start"}, red_start_o, 0);
    chk({tag, "_red_x"}, red_x_o, 0);
    chk({tag, "_red_m"}, red_m_o, 0);
    chk({tag, "_red_m_bl"}, red_m_bl_o, 0);
    chk({tag, "_red_mu"}, red_mu_o, 0);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
    chk({tag, "_rsp_data"}, rsp_data_o, 0);
    chk({tag, "_rsp_id"}, rsp_id_o, 0);
    chk({tag, "_err"}, err_o, 0);
  endtask

  task automatic do_cfg(input logic [63:0] m, input logic [63:0] bl, input logic [63:0] mu);
    int n = 0;
    cfg_valid_i = 1'b1; cfg_m_i = m; cfg_m_bl_i = bl; cfg_mu_i = mu;
    while (!cfg_ready_o && n < 200) begin tick(); n++; end
    chk("cfg_ready_timeout", (n < 200), 1);
    tick();
    cfg_valid_i = 1'b0;
  endtask

  task automatic set_rr_operands();
    for (int i = 0; i < NUM_REQ; i++) req_x_i[i*64 +: 64] = 64'(i*100 + 5);
  endtask

  // one request: issue strobe next cycle, response 16 cycles after the grant
  task automatic run_single(input int id, input logic [63:0] x, input logic [63:0] exp_data);
    int n = 0;
    clear_q();
    rsp_ready_i = 1'b1;
    req_x_i[id*64 +: 64] = x;
    req_valid_i = NUM_REQ'(1) << id;
    while (gnt_q.size() == 0 && n < 10) begin tick(); n++; end
    req_valid_i = '0;
    chk("single_grant", gnt_q.size(), 1);
    #1;
    chk("single_red_start", red_start_o, 1);
    chk("single_red_x", red_x_o, x);
    wait_rx(1, 40, "single_rsp_count");
    if (rx_data_q.size() == 1 && gnt_q.size() == 1) begin
      chk("single_rsp_data", rx_data_q[0], exp_data);
      chk("single_rsp_id", rx_id_q[0], id);
      chk("single_latency", rx_cyc_q[0] - gnt_cyc_q[0], RED_LAT + 2);
    end
  endtask

  initial begin
    int split, n;
    logic blocked_ok;
    vecs[0] = '{2, 64'd1000, 64'd30};
    vecs[1] = '{0, 64'd96,   64'd96};
    vecs[2] = '{1, 64'd97,   64'd0};
    vecs[3] = '{3, 64'd9408, 64'd96};
    vecs[4] = '{2, 64'd0,    64'd0};
    vecs[5] = '{1, 64'd291,  64'd0};

    req_valid_i = '0; req_x_i = '0; cfg_valid_i = 1'b0;
    cfg_m_i = '0; cfg_m_bl_i = '0; cfg_mu_i = '0; rsp_ready_i = 1'b0;

    #1 rst_ni = 1'b0;
    #5 chk_all_zero("reset");
    tick(); rst_ni = 1'b1;
    tick();
    chk("uncfg_cfg_ready", cfg_ready_o, 1);
    req_valid_i = '1; #1;
    chk("uncfg_no_grant", req_ready_o, 0);
    req_valid_i = '0;

    do_cfg(64'd97, 64'd7, 64'd168);
    chk("cfg_m", red_m_o, 97);
    chk("cfg_m_bl", red_m_bl_o, 7);
    chk("cfg_mu", red_mu_o, 168);
    chk("run_cfg_ready", cfg_ready_o, 0);

    // round robin: 0,1,2,3,0,1,2,3
    clear_q(); rsp_ready_i = 1'b1; set_rr_operands();
    req_valid_i = '1;
    repeat (8) tick();
    req_valid_i = '0;
    chk("rr_grant_count", gnt_q.size(), 8);
    wait_rx(8, 100, "rr_rsp_count");
    for (int k = 0; k < 8; k++) begin
      if (k < gnt_q.size()) chk("rr_grant_order", gnt_q[k], k % 4);
      if (k < rx_data_q.size()) begin
        chk("rr_rsp_id", rx_id_q[k], k % 4);
        chk("rr_rsp_data", rx_data_q[k], exp97[k % 4]);
      end
    end

    // backpressure: credits stop grants at FIFO_DEPTH
    clear_q(); rsp_ready_i = 1'b0;
    req_valid_i = '1;
    repeat (40) tick();
    chk("bp_grant_count", gnt_q.size(), FIFO_DEPTH);
    #1;
    chk("bp_no_grant", req_ready_o, 0);
    chk("bp_rsp_valid", rsp_valid_o, 1);
    req_valid_i = '0; rsp_ready_i = 1'b1;
    wait_rx(FIFO_DEPTH, 100, "bp_rsp_count");
    for (int k = 0; k < rx_data_q.size(); k++) begin
      chk("bp_rsp_id", rx_id_q[k], k % 4);
      chk("bp_rsp_data", rx_data_q[k], exp97[k % 4]);
    end
    repeat (5) tick();
    chk("bp_no_extra", rx_data_q.size(), FIFO_DEPTH);
    chk("bp_empty", rsp_valid_o, 0);

    for (int v = 0; v < 6; v++) run_single(vecs[v].id, vecs[v].x, vecs[v].exp_data);

    // reconfiguration mid-stream
    clear_q(); rsp_ready_i = 1'b1; set_rr_operands();
    req_valid_i = '1;
    repeat (3) tick();
    cfg_valid_i = 1'b1; cfg_m_i = 64'd101; cfg_m_bl_i = 64'd7; cfg_mu_i = 64'd162;
    #1;
    chk("recfg_grant_block", req_ready_o, 0);
    split = gnt_q.size();
    chk("recfg_pre_grants", split, 3);
    n = 0; blocked_ok = 1'b1;
    while (!cfg_ready_o && n < 100) begin
      tick(); #1;
      if (req_ready_o != '0) blocked_ok = 1'b0;
      n++;
    end
    chk("recfg_ready_timeout", (n < 100), 1);
    chk("recfg_blocked", blocked_ok, 1);
    chk("recfg_drained", rx_data_q.size() + int'(rsp_valid_o), split);
    tick();
    cfg_valid_i = 1'b0;
    repeat (4) tick();
    req_valid_i = '0;
    chk("recfg_m", red_m_o, 101);
    chk("recfg_mu", red_mu_o, 162);
    wait_rx(split + 4, 100, "recfg_rsp_count");
    for (int k = 0; k < rx_data_q.size(); k++) begin
      if (k < gnt_q.size()) chk("recfg_order", rx_id_q[k], gnt_q[k]);
      chk("recfg_rsp_data", rx_data_q[k], (k < split) ? exp97[rx_id_q[k]] : exp101[rx_id_q[k]]);
    end
    run_single(2, 64'd1000, 64'd91);

    // stray reducer valid
    clear_q();
    chk("err_before", err_o, 0);
    inj_v = 1'b1;
    tick();
    inj_v = 1'b0;
    #1;
    chk("err_set", err_o, 1);
    repeat (20) tick();
    chk("err_sticky", err_o, 1);
    chk("err_no_push", rx_data_q.size(), 0);
    chk("err_rsp_valid", rsp_valid_o, 0);

    // reset with work in flight
    clear_q(); rsp_ready_i = 1'b0;
    req_valid_i = '1;
    repeat (5) tick();
    req_valid_i = '0;
    repeat (3) tick();
    chk("rst_inflight_grants", gnt_q.size(), 5);
    rst_ni = 1'b0;
    #1 chk_all_zero("midrst");
    repeat (2) tick();
    rst_ni = 1'b1; rsp_ready_i = 1'b1;
    repeat (30) tick();
    chk("post_rst_no_rsp", rx_data_q.size(), 0);
    chk("post_rst_rsp_valid", rsp_valid_o, 0);
    chk("post_rst_err", err_o, 0);
    chk("post_rst_uncfg", cfg_ready_o, 1);
    chk("post_rst_m", red_m_o, 0);

    // zero modulus rejected
    do_cfg(64'd0, 64'd0, 64'd0);
    chk("badcfg_err", err_o, 1);
    chk("badcfg_uncfg", cfg_ready_o, 1);
    chk("badcfg_m", red_m_o, 0);
    req_valid_i = '1; #1;
    chk("badcfg_no_grant", req_ready_o, 0);
    req_valid_i = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/barrett_sched.md
BARRETT_SCHED -- requirements
Module: barrett_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one pipelined Barrett reducer.
REQ-002 Parameter RED_LAT, default 14: fixed reducer latency from red_start_o to red_valid_i, in cycles.
REQ-003 Parameter FIFO_DEPTH, default 16, power of two: number of response FIFO entries.
REQ-004 clk_i  in  1  clock, rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 req_valid_i  in  NUM_REQ  per-requester request valid.
REQ-007 req_ready_o  out  NUM_REQ  per-requester grant; at most one bit high.
REQ-008 req_x_i  in  NUM_REQ*64  packed operands; requester i occupies bits [64i+63:64i].
REQ-009 cfg_valid_i / cfg_ready_o  in/out  1/1  configuration handshake.
REQ-010 cfg_m_i, cfg_m_bl_i, cfg_mu_i  in  64 each  modulus, modulus bit length, precomputed mu.
REQ-011 red_start_o, red_x_o  out  1/64  reducer issue strobe and operand, both registered.
REQ-012 red_m_o, red_m_bl_o, red_mu_o  out  64 each  active configuration, registered.
REQ-013 red_result_i, red_valid_i  in  64/1  reducer result and valid.
REQ-014 rsp_valid_o / rsp_ready_i  out/in  1/1  response handshake.
REQ-015 rsp_data_o, rsp_id_o  out  64 / $clog2(NUM_REQ)  reduced value and originating requester.
REQ-016 err_o  out  1  sticky protocol error flag.

Function
REQ-017 The FSM SHALL use states UNCFG, RUN and DRAIN, and SHALL reset into UNCFG.
REQ-018 In UNCFG, cfg_ready_o SHALL be 1; a cfg handshake SHALL latch the configuration and move to RUN, except that cfg_m_i==0 SHALL set err_o and leave the FSM in UNCFG.
REQ-019 In RUN, cfg_valid_i=1 SHALL move the FSM to DRAIN and SHALL block further grants.
REQ-020 In DRAIN, cfg_ready_o SHALL be 1 only when inflight==0; the handshake SHALL latch the new configuration and return to RUN, with UNCFG rules applying to m==0.
REQ-021 Grants SHALL be issued only in RUN with credits>0, where credits = FIFO_DEPTH - fifo_count - inflight; at most one grant per cycle.
REQ-022 Arbitration SHALL be round-robin, with priority starting at the requester after the last granted one; req_ready_o SHALL be combinational from req_valid_i, state, credits and the priority pointer.
REQ-023 A request handshake in cycle t SHALL produce red_start_o=1 and red_x_o = that operand in cycle t+1.
REQ-024 A tag pipe of RED_LAT stages SHALL carry {valid, id} aligned with red_valid_i.
REQ-025 inflight SHALL increment on grant and decrement when the tag pipe output is valid; simultaneous increment and decrement SHALL leave it unchanged.
REQ-026 When red_valid_i and the tag output are both valid, {id, red_result_i} SHALL be pushed into the FIFO.
REQ-027 A mismatch (either valid without the other) SHALL set err_o and push nothing.
REQ-028 The FIFO SHALL be first-word-fall-through with no bypass: rsp_valid_o = !empty, with data and id taken from the head.
REQ-029 A response SHALL pop on rsp_valid_o && rsp_ready_i; simultaneous push and pop SHALL be legal at any fill level.
REQ-030 The credit rule SHALL guarantee that no push occurs when the FIFO is full.
REQ-031 End-to-end latency SHALL be: grant at t, then rsp_valid_o at t+2+RED_LAT when the FIFO was empty.
REQ-032 Responses SHALL be returned in grant order.

Reset
REQ-033 On rst_ni low, all of the following SHALL clear asynchronously: state to UNCFG, all outputs to 0, configuration registers to 0, tag pipe, inflight, FIFO pointers, RR pointer (pointing at requester 0), err_o.
REQ-034 Reset during operation SHALL discard all in-flight and buffered results, and no stale response SHALL emerge after reset release.

Structure
REQ-035 The state typedef sched_state_t and RED_LAT default SHALL live in the shared package barrett_pkg.
REQ-036 The response FIFO SHALL be a sub-module, rsp_fifo; the tag pipe SHALL reuse the existing shiftreg module.

Verification
REQ-037 Bench, single request: m=97, m_bl=7, mu=168; requester 2 sends x=1000 at cycle t -> rsp_data_o=30, rsp_id_o=2, rsp_valid_o at t+16.
REQ-038 Bench, round-robin: all four requesters hold valid with x=i*100+5 -> grant order 0,1,2,3,0,...; responses 5,8,11,14 (mod 97).
REQ-039 Bench, backpressure: rsp_ready_i=0 with all requesters valid -> exactly 16 grants, then req_ready_o=0; releasing rsp_ready_i drains all 16 responses in order with none lost.
REQ-040 Bench, reconfiguration mid-stream: cfg_valid_i with m=101, m_bl=7, mu=162 -> grants stop, cfg_ready_o rises only at inflight==0, earlier results use m=97, later ones m=101 (x=1000 -> 91).
REQ-041 Bench, protocol error: red_valid_i pulsed with no outstanding tag -> err_o=1 and held until reset, no FIFO push.
REQ-042 Bench, reset mid-operation: rst_ni pulsed with 5 requests in flight -> outputs 0, state UNCFG, no rsp_valid_o after release.
